// File: rtl/toggle_activity_monitor_pkg.sv
// Shared types and width helpers for the toggle activity monitor.
// Holds FSM encoding, clog2 width helpers and energy saturation.
package pea_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACCUM = 2'd2
  } state_e;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int tot_w(input int width, input int window);
    return $clog2(width * window + 1);
  endfunction

  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic logic [31:0] sat_energy(
    input logic [31:0] e,
    input int          w
  );
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (e > mx) ? mx : e;
  endfunction

endpackage

// File: rtl/toggle_activity_monitor_if.sv
// Window-result port: valid/ready plus toggle_total, hot_bit, energy_est.
// master drives the result, slave owns win_ready.
interface toggle_activity_monitor_if #(
  parameter int WIDTH    = 4,
  parameter int WINDOW   = 16,
  parameter int ENERGY_W = 16
);
  import pea_pkg::*;

  localparam int TW = tot_w(WIDTH, WINDOW);
  localparam int HW = idx_w(WIDTH);

  logic                win_valid;
  logic                win_ready;
  logic [TW-1:0]       toggle_total;
  logic [HW-1:0]       hot_bit;
  logic [ENERGY_W-1:0] energy_est;

  modport master (
    output win_valid,
    output toggle_total,
    output hot_bit,
    output energy_est,
    input  win_ready
  );

  modport slave (
    input  win_valid,
    input  toggle_total,
    input  hot_bit,
    input  energy_est,
    output win_ready
  );

endinterface

// File: rtl/toggle_activity_monitor_popcount.sv
// Combinational popcount of a_i ^ b_i (bits that toggled this sample).
// Ports: a_i, b_i WIDTH-bit operands; cnt_o number of differing bits.
module toggle_popcount #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [CW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + CW'(a_i[i] ^ b_i[i]);
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Per-window toggle counter: total toggles, hottest bit, energy estimate.
// Ports: clk, rst_n, en, sample_in, win (result port, master), overrun.
module toggle_activity_monitor
  import pea_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int WINDOW     = 16,
  parameter int CAP_WEIGHT = 3,
  parameter int ENERGY_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  toggle_activity_monitor_if.master win,
  output logic             overrun
);

  localparam int CW = cnt_w(WINDOW);
  localparam int TW = tot_w(WIDTH, WINDOW);
  localparam int HW = idx_w(WIDTH);
  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  state_e                   state_q;
  logic [WIDTH-1:0]         prev_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [TW-1:0]            tot_q;
  logic [CW-1:0]            smp_q;

  logic                valid_q;
  logic [TW-1:0]       total_q;
  logic [HW-1:0]       hot_q;
  logic [ENERGY_W-1:0] energy_q;
  logic                ovr_q;

  logic [PW-1:0]            pc;
  logic [WIDTH-1:0][CW-1:0] cnt_d;
  logic [TW-1:0]            tot_d;
  logic [HW-1:0]            hot_d;
  logic [CW-1:0]            best;
  logic [31:0]              e_full;
  logic [ENERGY_W-1:0]      energy_d;
  logic                     last;
  logic                     load_ok;

  toggle_popcount #(
    .WIDTH (WIDTH),
    .CW    (PW)
  ) u_pop (
    .a_i   (sample_in),
    .b_i   (prev_q),
    .cnt_o (pc)
  );

  // Window results include the transition being counted this cycle.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(sample_in[i] ^ prev_q[i]);
    end
    tot_d = tot_q + TW'(pc);
  end

  // Strict > keeps the lowest index on ties.
  always_comb begin
    hot_d = '0;
    best  = cnt_d[0];
    for (int i = 1; i < WIDTH; i++) begin
      if (cnt_d[i] > best) begin
        best  = cnt_d[i];
        hot_d = HW'(i);
      end
    end
  end

  always_comb begin
    e_full   = 32'(tot_d) * 32'(CAP_WEIGHT);
    energy_d = ENERGY_W'(sat_energy(e_full, ENERGY_W));
    last     = (smp_q == LAST);
    load_ok  = !valid_q || win.win_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      cnt_q    <= '0;
      tot_q    <= '0;
      smp_q    <= '0;
      valid_q  <= 1'b0;
      total_q  <= '0;
      hot_q    <= '0;
      energy_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (valid_q && win.win_ready) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (en) state_q <= PRIME;
        end
        PRIME: begin
          if (en) begin
            prev_q  <= sample_in;
            state_q <= ACCUM;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCUM: begin
          if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tot_q   <= '0;
            smp_q   <= '0;
          end else begin
            // prev always advances so the next window has no gap.
            prev_q <= sample_in;
            if (last) begin
              cnt_q <= '0;
              tot_q <= '0;
              smp_q <= '0;
              if (load_ok) begin
                valid_q  <= 1'b1;
                total_q  <= tot_d;
                hot_q    <= hot_d;
                energy_q <= energy_d;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_d;
              tot_q <= tot_d;
              smp_q <= smp_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win.win_valid    = valid_q;
  assign win.toggle_total = total_q;
  assign win.hot_bit      = hot_q;
  assign win.energy_est   = energy_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: directed segments plus random traffic.
// Two instances share stimulus; the second has a 6-bit energy output.
module tb_toggle_activity_monitor;

  localparam int W   = 4;
  localparam int N   = 16;
  localparam int CAP = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] smp = '0;
  logic         ovr_a;
  logic         ovr_b;

  always #5 clk = ~clk;

  toggle_activity_monitor_if #(.WIDTH(W), .WINDOW(N), .ENERGY_W(16)) bus_a();
  toggle_activity_monitor_if #(.WIDTH(W), .WINDOW(N), .ENERGY_W(6))  bus_b();

  assign bus_a.win_ready = rdy;
  assign bus_b.win_ready = rdy;

  toggle_activity_monitor #(
    .WIDTH(W), .WINDOW(N), .CAP_WEIGHT(CAP), .ENERGY_W(16)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample_in (smp),
    .win       (bus_a.master),
    .overrun   (ovr_a)
  );

  toggle_activity_monitor #(
    .WIDTH(W), .WINDOW(N), .CAP_WEIGHT(CAP), .ENERGY_W(6)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample_in (smp),
    .win       (bus_b.master),
    .overrun   (ovr_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference: samples seen since the window's priming sample.
  bit           awake;
  logic [W-1:0] hist[$];
  bit           m_valid;
  bit           m_ovr;
  int           m_tot;
  int           m_hot;

  int pin_tot = -1;
  int pin_hot = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int emin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    awake   = 0;
    hist.delete();
    m_valid = 0;
    m_ovr   = 0;
    m_tot   = 0;
    m_hot   = 0;
  endtask

  task automatic check_outputs();
    chk("valid",    32'(bus_a.win_valid),    32'(m_valid));
    chk("valid_b",  32'(bus_b.win_valid),    32'(m_valid));
    chk("total",    32'(bus_a.toggle_total), 32'(m_tot));
    chk("hot",      32'(bus_a.hot_bit),      32'(m_hot));
    chk("energy",   32'(bus_a.energy_est),   32'(emin(m_tot * CAP, 65535)));
    chk("energy6",  32'(bus_b.energy_est),   32'(emin(m_tot * CAP, 63)));
    chk("overrun",  32'(ovr_a),              32'(m_ovr));
    chk("overrun_b",32'(ovr_b),              32'(m_ovr));
  endtask

  task automatic step();
    bit           old_v;
    bit           done;
    int           c[W];
    int           t;
    int           h;
    logic [W-1:0] x;
    logic [W-1:0] keep;
    @(posedge clk);
    old_v = m_valid;
    done  = 0;
    t     = 0;
    h     = 0;
    if (m_valid && rdy) m_valid = 0;
    if (!en) begin
      awake = 0;
      hist.delete();
    end else if (!awake) begin
      awake = 1;
    end else begin
      hist.push_back(smp);
      if (hist.size() == N + 1) begin
        for (int b = 0; b < W; b++) c[b] = 0;
        for (int k = 0; k < N; k++) begin
          x = hist[k] ^ hist[k+1];
          for (int b = 0; b < W; b++) c[b] += int'(x[b]);
        end
        for (int b = 0; b < W; b++) begin
          t += c[b];
          if (c[b] > c[h]) h = b;
        end
        keep = hist[N];
        hist.delete();
        hist.push_back(keep);
        done = 1;
      end
    end
    if (done) begin
      if (!old_v || rdy) begin
        m_valid = 1;
        m_tot   = t;
        m_hot   = h;
      end else begin
        m_ovr = 1;
      end
    end
    #1;
    check_outputs();
    if (pin_tot >= 0 && bus_a.win_valid) begin
      chk("pin_total", 32'(bus_a.toggle_total), 32'(pin_tot));
      chk("pin_hot",   32'(bus_a.hot_bit),      32'(pin_hot));
    end
  endtask

  initial begin
    int cnt;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Counter-stage driver, 0..15 wrapping.
    rdy = 1'b1;
    en  = 1'b1;
    cnt = 0;
    pin_tot = 30;
    pin_hot = 0;
    repeat (70) begin
      smp = W'(cnt);
      step();
      cnt = (cnt + 1) % 16;
    end
    pin_tot = -1;
    en = 1'b0;
    repeat (3) step();

    // Constant bus: no toggles.
    en  = 1'b1;
    smp = 4'hA;
    pin_tot = 0;
    pin_hot = 0;
    repeat (40) step();
    pin_tot = -1;
    en = 1'b0;
    repeat (3) step();

    // Alternating 0/F: every bit toggles every sample.
    en = 1'b1;
    pin_tot = 64;
    pin_hot = 0;
    for (int i = 0; i < 40; i++) begin
      smp = (i % 2 == 0) ? 4'h0 : 4'hF;
      step();
    end
    pin_tot = -1;

    // Consumer stalls across several windows.
    rdy = 1'b0;
    repeat (50) begin
      smp = W'($urandom);
      step();
    end
    chk("stall_overrun", 32'(ovr_a), 32'd1);
    rdy = 1'b1;
    repeat (20) begin
      smp = W'($urandom);
      step();
    end

    // Abort mid-window, then re-enable.
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (9) begin
      smp = W'($urandom);
      step();
    end
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (40) begin
      smp = W'($urandom);
      step();
    end

    // Async reset while a result is held.
    rdy = 1'b0;
    repeat (25) begin
      smp = W'($urandom);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst_n = 1'b1;

    // Random traffic.
    repeat (3000) begin
      en  = ($urandom_range(0, 59) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      smp = W'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
